axi_cmd_arbiter: RTL and testbench
==================================

Name: axi_cmd_arbiter

Overview:
- Shares the single user-side command port of axi_master between NUM_REQ requesters, using round-robin arbitration.
- Sequences each granted request onto the master's valid/valid_r pulse interface and waits for the master's ready completion pulse.
- Returns completion, read data and a timeout error to the granted requester.
- Sits between client logic (DMA, CPU bridge, test sequencers) and axi_master; handles one transaction in flight at a time.

Parameters:
- NUM_REQ, 2, number of requesters (2..8)
- ADDR_W, 32, address width
- DATA_W, 32, data width; strobe width is DATA_W/8
- TIMEOUT, 64, max cycles in WAIT before error; 0 disables the timeout

Ports:
- ACLK  in  1  clock, rising edge
- ARESET  in  1  asynchronous, active-low reset
- req  in  NUM_REQ  per-requester request level; held until matching done
- req_we  in  NUM_REQ  1=write, 0=read, per requester
- req_addr  in  NUM_REQ*ADDR_W  flattened addresses, requester i at [i*ADDR_W +: ADDR_W]
- req_wdata  in  NUM_REQ*DATA_W  flattened write data
- req_wstrb  in  NUM_REQ*DATA_W/8  flattened byte strobes
- gnt  out  NUM_REQ  one-hot, current owner; held from ISSUE through RESP
- done  out  NUM_REQ  one-cycle completion pulse to the owner
- err  out  1  valid with done; 1 = timed out
- rdata  out  DATA_W  read data, valid with done on reads
- m_valid  out  1  write command pulse to axi_master valid
- m_valid_r  out  1  read command pulse to axi_master valid_r
- m_aw_addr  out  ADDR_W  to master aw_addr
- m_w_data  out  DATA_W  to master w_data
- m_w_strb  out  DATA_W/8  to master w_strb
- m_ar_addr  out  ADDR_W  to master ar_addr
- m_ready  in  1  master completion pulse (write response or read data)
- m_r_data  in  DATA_W  master read data, valid when m_ready on a read

Behaviour:
- Reset (ARESET=0, async) drives all outputs to 0, state to IDLE, RR pointer to NUM_REQ-1 (so requester 0 wins first) and the timeout counter to 0.
- States and transitions:
  - IDLE: if any req bit is set, grant the first requester at or after pointer+1 (wrapping modulo NUM_REQ), latch its fields, update the pointer, go to ISSUE.
  - ISSUE: exactly one cycle. Assert m_valid (we=1) or m_valid_r (we=0). Address, data and strobe are driven from the latch; unused command outputs are 0. Go to WAIT.
  - WAIT: on m_ready, capture m_r_data (reads only; writes give rdata=0), go to RESP. Otherwise increment the counter. If TIMEOUT!=0 and the counter reaches TIMEOUT-1, set err=1 and rdata=0, go to RESP with a recover flag set.
  - RESP: done[owner]=1 for one cycle. gnt clears on exit. Go to IDLE, or to RECOVER if the flag is set.
  - RECOVER: gnt=0. Wait for the late m_ready, swallow it, go to IDLE. New requests are not granted in this state.
- Latency: req seen in IDLE at cycle N gives gnt and ISSUE at N+1, WAIT from N+2, and done one cycle after m_ready. Minimum occupancy is 4 cycles. The next grant is possible the cycle after RESP.
- Command outputs hold their latched values from ISSUE until RESP. Only the valid pulses are single-cycle.
- A requester dropping req after grant does not abort the transaction; done still pulses.
- req changes from non-owners during a transaction are ignored; arbitration happens only in IDLE.
- m_ready is ignored in IDLE and ISSUE.
- m_ready arriving in the same cycle as the timeout expiry counts as success (err=0) and skips RECOVER.
- Strobe is passed through unchanged. The arbiter does no address alignment or bounds checking.
- Reset asserted mid-transaction: immediate return to the reset state, no done pulse. axi_master is reset by the same ARESET.

Decomposition:
- Package axi_arb_pkg: state encoding (IDLE, ISSUE, WAIT, RESP, RECOVER), default widths, strobe-width function.
- Sub-module rr_arbiter: combinational one-hot grant from the req vector and pointer, plus the pointer-update register.
- The top-level module holds the FSM, the latch, the timeout counter and the master interface.

Test Plan:
- Single write: req[0]=1, we=1, addr=0, wdata=32'h12345678, wstrb=4'b0001 -> one-cycle m_valid with those values; done[0] the cycle after m_ready; err=0; memory byte 0 = 8'h78.
- Single read: req[1]=1, we=0, addr=0 after the write above -> one-cycle m_valid_r with m_ar_addr=0; done[1] with rdata low byte 8'h78.
- Contention: req=2'b11 held continuously, from reset -> grant order 0,1,0,1; no requester is granted twice in a row while the other waits.
- Timeout: TIMEOUT=8, m_ready held low -> done pulse with err=1 and rdata=0 after 8 WAIT cycles; no grant until an injected m_ready; then normal operation resumes.
- Reset mid-WAIT: pull ARESET low during WAIT -> gnt, done, m_valid and m_valid_r are all 0 immediately; the first grant after release goes to requester 0.
- Request withdrawn: req[0] dropped one cycle after grant -> the command still issues and done[0] still pulses; requester 1 is granted next.

Source files
------------

// File: rtl/axi_arb_pkg.sv
// Shared definitions for the axi_master command arbiter.
//   - FSM state encoding (3-bit, legacy-compatible localparams)
//   - default widths and counts
//   - helpers for strobe width, pointer width and counter width
package axi_arb_pkg;

  localparam int DEF_NUM_REQ = 2;
  localparam int DEF_ADDR_W  = 32;
  localparam int DEF_DATA_W  = 32;
  localparam int DEF_TIMEOUT = 64;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_ISSUE   = 3'd1;
  localparam logic [2:0] ST_WAIT    = 3'd2;
  localparam logic [2:0] ST_RESP    = 3'd3;
  localparam logic [2:0] ST_RECOVER = 3'd4;

  function automatic int strb_w(input int data_w);
    return data_w / 8;
  endfunction

  // Width of a requester index; at least one bit.
  function automatic int ptr_w(input int num_req);
    return (num_req > 1) ? $clog2(num_req) : 1;
  endfunction

  // Width of the WAIT counter: must hold TIMEOUT-1.
  function automatic int cnt_w(input int timeout);
    return (timeout > 1) ? $clog2(timeout) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter.
//   clk_i, rst_ni : clock, async active-low reset
//   req_i         : request vector
//   advance_i     : accept the current grant and move the pointer to it
//   gnt_o         : one-hot grant, first request at or after pointer+1
//   gnt_idx_o     : binary index of gnt_o
//   any_o         : at least one request pending
// The pointer resets to NUM_REQ-1 so requester 0 wins the first round.
module rr_arbiter
  import axi_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  localparam int PTR_W  = ptr_w(NUM_REQ)
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               advance_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [PTR_W-1:0]   gnt_idx_o,
  output logic               any_o
);

  logic [PTR_W-1:0] ptr_q, ptr_d;

  always_comb begin
    int               idx;
    logic             found;
    logic [PTR_W-1:0] idx_w;
    idx       = 0;
    idx_w     = '0;
    found     = 1'b0;
    gnt_o     = '0;
    gnt_idx_o = '0;
    // Scan pointer+1 .. pointer+NUM_REQ, wrapping, first hit wins.
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx   = (int'(ptr_q) + i) % NUM_REQ;
      idx_w = PTR_W'(idx);
      if (!found && req_i[idx_w]) begin
        found        = 1'b1;
        gnt_o[idx_w] = 1'b1;
        gnt_idx_o    = idx_w;
      end
    end
  end

  assign any_o = |req_i;
  assign ptr_d = advance_i ? gnt_idx_o : ptr_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) ptr_q <= PTR_W'(NUM_REQ - 1);
    else         ptr_q <= ptr_d;
  end

endmodule

// File: rtl/axi_cmd_arbiter.sv
// Shares the axi_master user command port between NUM_REQ requesters.
//   ACLK, ARESET           : clock, async active-low reset
//   req/req_we/req_addr/req_wdata/req_wstrb : per-requester command (flattened)
//   gnt, done, err, rdata  : owner grant, completion pulse, timeout flag, read data
//   m_valid/m_valid_r      : one-cycle write/read command pulses to the master
//   m_aw_addr/m_w_data/m_w_strb/m_ar_addr : command fields, held ISSUE..RESP
//   m_ready, m_r_data      : master completion pulse and read data
//   dbg_state              : current FSM state
// Handshake: a requester raises req and holds it with its fields stable until
// done pulses for it; the master sees exactly one valid/valid_r pulse per
// transaction and answers with exactly one m_ready pulse. One transaction is
// in flight at a time; arbitration only happens in IDLE.
module axi_cmd_arbiter
  import axi_arb_pkg::*;
#(
  parameter int NUM_REQ  = DEF_NUM_REQ,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int TIMEOUT  = DEF_TIMEOUT,
  localparam int STRB_W  = strb_w(DATA_W),
  localparam int PTR_W   = ptr_w(NUM_REQ),
  localparam int CNT_W   = cnt_w(TIMEOUT)
) (
  input  logic                        ACLK,
  input  logic                        ARESET,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ-1:0]          req_we,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]   req_wdata,
  input  logic [NUM_REQ*STRB_W-1:0]   req_wstrb,
  output logic [NUM_REQ-1:0]          gnt,
  output logic [NUM_REQ-1:0]          done,
  output logic                        err,
  output logic [DATA_W-1:0]           rdata,
  output logic                        m_valid,
  output logic                        m_valid_r,
  output logic [ADDR_W-1:0]           m_aw_addr,
  output logic [DATA_W-1:0]           m_w_data,
  output logic [STRB_W-1:0]           m_w_strb,
  output logic [ADDR_W-1:0]           m_ar_addr,
  input  logic                        m_ready,
  input  logic [DATA_W-1:0]           m_r_data,
  output logic [2:0]                  dbg_state
);

  logic [ADDR_W-1:0] addr_arr  [NUM_REQ];
  logic [DATA_W-1:0] wdata_arr [NUM_REQ];
  logic [STRB_W-1:0] wstrb_arr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign addr_arr[g]  = req_addr[g*ADDR_W +: ADDR_W];
    assign wdata_arr[g] = req_wdata[g*DATA_W +: DATA_W];
    assign wstrb_arr[g] = req_wstrb[g*STRB_W +: STRB_W];
  end

  logic [2:0]         state_q, state_d;
  logic [NUM_REQ-1:0] owner_q, owner_d;
  logic               we_q, we_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;
  logic [STRB_W-1:0]  wstrb_q, wstrb_d;
  logic [DATA_W-1:0]  rdata_q, rdata_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  // Set on timeout: drives err in RESP and sends the FSM through RECOVER.
  logic               to_q, to_d;

  logic [NUM_REQ-1:0] arb_gnt;
  logic [PTR_W-1:0]   arb_idx;
  logic               arb_any;
  logic               arb_adv;

  assign arb_adv = (state_q == ST_IDLE) && arb_any;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .clk_i     (ACLK),
    .rst_ni    (ARESET),
    .req_i     (req),
    .advance_i (arb_adv),
    .gnt_o     (arb_gnt),
    .gnt_idx_o (arb_idx),
    .any_o     (arb_any)
  );

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
    to_d    = to_q;
    case (state_q)
      ST_IDLE: begin
        if (arb_any) begin
          owner_d = arb_gnt;
          we_d    = req_we[arb_idx];
          addr_d  = addr_arr[arb_idx];
          wdata_d = wdata_arr[arb_idx];
          wstrb_d = wstrb_arr[arb_idx];
          to_d    = 1'b0;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        cnt_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // m_ready has priority so a response on the expiry cycle still succeeds.
        if (m_ready) begin
          rdata_d = we_q ? '0 : m_r_data;
          to_d    = 1'b0;
          state_d = ST_RESP;
        end else if ((TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT - 1))) begin
          rdata_d = '0;
          to_d    = 1'b1;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RESP: begin
        state_d = to_q ? ST_RECOVER : ST_IDLE;
      end
      ST_RECOVER: begin
        // The master still owes one m_ready for the abandoned command.
        if (m_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESET) begin
    if (!ARESET) begin
      state_q <= ST_IDLE;
      owner_q <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
      to_q    <= to_d;
    end
  end

  logic busy;
  assign busy = (state_q == ST_ISSUE) || (state_q == ST_WAIT) || (state_q == ST_RESP);

  assign gnt       = busy ? owner_q : '0;
  assign done      = (state_q == ST_RESP) ? owner_q : '0;
  assign err       = (state_q == ST_RESP) && to_q;
  assign rdata     = (state_q == ST_RESP) ? rdata_q : '0;
  assign m_valid   = (state_q == ST_ISSUE) && we_q;
  assign m_valid_r = (state_q == ST_ISSUE) && !we_q;
  assign m_aw_addr = (busy && we_q)  ? addr_q  : '0;
  assign m_w_data  = (busy && we_q)  ? wdata_q : '0;
  assign m_w_strb  = (busy && we_q)  ? wstrb_q : '0;
  assign m_ar_addr = (busy && !we_q) ? addr_q  : '0;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_axi_cmd_arbiter.sv
// Directed bench for axi_cmd_arbiter (NUM_REQ=2, 32-bit, TIMEOUT=8).
// The bench plays the axi_master side by hand; all expected values are
// hand-computed constants.
module tb_axi_cmd_arbiter;
  import axi_arb_pkg::*;

  logic        ACLK;
  logic        ARESET;
  logic [1:0]  req, req_we;
  logic [63:0] req_addr, req_wdata;
  logic [7:0]  req_wstrb;
  logic [1:0]  gnt, done;
  logic        err;
  logic [31:0] rdata;
  logic        m_valid, m_valid_r;
  logic [31:0] m_aw_addr, m_w_data, m_ar_addr;
  logic [3:0]  m_w_strb;
  logic        m_ready;
  logic [31:0] m_r_data;
  logic [2:0]  dbg_state;

  int n_chk  = 0;
  int n_pass = 0;

  axi_cmd_arbiter #(.NUM_REQ(2), .ADDR_W(32), .DATA_W(32), .TIMEOUT(8)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .req(req), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .gnt(gnt), .done(done), .err(err), .rdata(rdata),
    .m_valid(m_valid), .m_valid_r(m_valid_r),
    .m_aw_addr(m_aw_addr), .m_w_data(m_w_data), .m_w_strb(m_w_strb),
    .m_ar_addr(m_ar_addr), .m_ready(m_ready), .m_r_data(m_r_data),
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  logic [1:0]  exp_order [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
  logic [31:0] mem0;

  initial begin
    ARESET = 1'b0; req = '0; req_we = '0; req_addr = '0; req_wdata = '0;
    req_wstrb = '0; m_ready = 1'b0; m_r_data = '0; mem0 = 32'h0;
    tick(); tick();
    chk("rst_gnt", gnt, 2'b00);
    chk("rst_done", done, 2'b00);
    chk("rst_mvalid", {m_valid, m_valid_r}, 2'b00);
    chk("rst_state", dbg_state, ST_IDLE);
    ARESET = 1'b1;

    // single write from requester 0
    req_we = 2'b01; req_addr[31:0] = 32'h0; req_wdata[31:0] = 32'h12345678;
    req_wstrb[3:0] = 4'b0001; req = 2'b01;
    mem0[7:0] = 8'h78;  // byte 0 enabled by strobe
    tick();
    chk("wr_gnt", gnt, 2'b01);
    chk("wr_valid", {m_valid, m_valid_r}, 2'b10);
    chk("wr_awaddr", m_aw_addr, 32'h0);
    chk("wr_wdata", m_w_data, 32'h12345678);
    chk("wr_wstrb", m_w_strb, 4'b0001);
    chk("wr_araddr", m_ar_addr, 32'h0);
    tick();
    chk("wr_wait_state", dbg_state, ST_WAIT);
    chk("wr_wait_valid", {m_valid, m_valid_r}, 2'b00);
    chk("wr_wait_hold", m_w_data, 32'h12345678);
    chk("wr_wait_done", done, 2'b00);
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0; req = 2'b00;
    chk("wr_done", done, 2'b01);
    chk("wr_err", err, 1'b0);
    chk("wr_rdata", rdata, 32'h0);
    tick();
    chk("wr_idle_done", done, 2'b00);
    chk("wr_idle_gnt", gnt, 2'b00);

    // single read from requester 1
    req_we = 2'b00; req_addr[63:32] = 32'h0; req = 2'b10;
    tick();
    chk("rd_gnt", gnt, 2'b10);
    chk("rd_valid", {m_valid, m_valid_r}, 2'b01);
    chk("rd_araddr", m_ar_addr, 32'h0);
    chk("rd_unused_wdata", m_w_data, 32'h0);
    tick();
    m_ready = 1'b1; m_r_data = mem0;
    tick();
    m_ready = 1'b0; m_r_data = '0; req = 2'b00;
    chk("rd_done", done, 2'b10);
    chk("rd_rdata", rdata, 32'h00000078);
    chk("rd_err", err, 1'b0);
    tick();

    // contention from reset: order 0,1,0,1
    ARESET = 1'b0; tick(); ARESET = 1'b1;
    req_we = 2'b01; req_addr = {32'h200, 32'h100}; req = 2'b11;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("cont_gnt", gnt, exp_order[k]);
      chk("cont_addr", (exp_order[k] == 2'b01) ? m_aw_addr : m_ar_addr,
          (exp_order[k] == 2'b01) ? 32'h100 : 32'h200);
      tick();
      m_ready = 1'b1;
      tick();
      m_ready = 1'b0;
      chk("cont_done", done, exp_order[k]);
      tick();
    end
    req = 2'b00;

    // timeout on a read from requester 0 (pointer now at 1)
    req_we = 2'b00; req_addr[31:0] = 32'h40; req = 2'b01; m_r_data = 32'hDEADBEEF;
    tick();
    chk("to_gnt", gnt, 2'b01);
    tick();
    chk("to_wait0", dbg_state, ST_WAIT);
    for (int i = 1; i < 8; i++) begin
      tick();
      chk("to_wait", {dbg_state, done}, {ST_WAIT, 2'b00});
    end
    tick();
    req = 2'b00;
    chk("to_done", done, 2'b01);
    chk("to_err", err, 1'b1);
    chk("to_rdata", rdata, 32'h0);
    tick();
    chk("to_recover", dbg_state, ST_RECOVER);
    chk("to_rec_gnt", gnt, 2'b00);
    req = 2'b11;
    tick(); chk("to_rec_nogrant1", gnt, 2'b00);
    tick(); chk("to_rec_nogrant2", gnt, 2'b00);
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0; m_r_data = '0;
    chk("to_back_idle", dbg_state, ST_IDLE);
    tick();
    chk("to_next_gnt", gnt, 2'b10);
    tick();
    m_ready = 1'b1; m_r_data = 32'h0BADF00D;
    tick();
    m_ready = 1'b0; m_r_data = '0; req = 2'b00;
    chk("to_next_done", done, 2'b10);
    chk("to_next_err", err, 1'b0);
    chk("to_next_rdata", rdata, 32'h0BADF00D);
    tick();

    // m_ready on the expiry cycle counts as success (pointer at 1)
    req_we = 2'b01; req = 2'b01;
    tick();
    chk("edge_gnt", gnt, 2'b01);
    tick();
    for (int i = 1; i < 8; i++) tick();
    chk("edge_last_wait", dbg_state, ST_WAIT);
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0; req = 2'b00;
    chk("edge_done", done, 2'b01);
    chk("edge_err", err, 1'b0);
    tick();
    chk("edge_no_recover", dbg_state, ST_IDLE);

    // reset during WAIT (pointer at 0)
    req = 2'b01;
    tick();
    chk("rstw_gnt", gnt, 2'b01);
    tick();
    chk("rstw_wait", dbg_state, ST_WAIT);
    ARESET = 1'b0;
    #1;
    chk("rstw_gnt0", gnt, 2'b00);
    chk("rstw_done0", done, 2'b00);
    chk("rstw_valid0", {m_valid, m_valid_r}, 2'b00);
    chk("rstw_idle", dbg_state, ST_IDLE);
    req = 2'b11;
    #1 ARESET = 1'b1;
    tick();
    chk("rstw_first_gnt", gnt, 2'b01);
    tick();
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0; req = 2'b00;
    chk("rstw_done", done, 2'b01);
    tick();

    // request withdrawn after grant
    ARESET = 1'b0; tick(); ARESET = 1'b1;
    req_we = 2'b01; req_addr = {32'h8, 32'h4}; req = 2'b11;
    tick();
    chk("wd_gnt", gnt, 2'b01);
    chk("wd_valid", m_valid, 1'b1);
    req = 2'b10;
    tick();
    chk("wd_wait_gnt", gnt, 2'b01);
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    chk("wd_done", done, 2'b01);
    tick();
    tick();
    chk("wd_next_gnt", gnt, 2'b10);
    chk("wd_next_valid_r", m_valid_r, 1'b1);
    chk("wd_next_araddr", m_ar_addr, 32'h8);
    m_ready = 1'b1;  // must be ignored in ISSUE
    tick();
    m_ready = 1'b0;
    tick();
    chk("wd_ready_ignored", {dbg_state, done}, {ST_WAIT, 2'b00});
    m_ready = 1'b1; m_r_data = 32'hA5A55A5A;
    tick();
    m_ready = 1'b0; m_r_data = '0; req = 2'b00;
    chk("wd_next_done", done, 2'b10);
    chk("wd_next_rdata", rdata, 32'hA5A55A5A);
    tick();
    chk("wd_final_idle", dbg_state, ST_IDLE);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
